// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e      : converter FSM states
//   BCD_DIGIT_W  : bits per BCD digit
//   bcd_max()    : largest value representable in a given number of BCD digits
package bin_to_bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // 10^digits - 1, evaluated at elaboration time
  function automatic int unsigned bcd_max(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_adj.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   digit_i : scratch nibble before the shift
//   digit_o : corrected nibble
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(5)) begin
      digit_o = digit_i + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: unsigned binary in, packed BCD out.
// One value accepted per handshake, one bit processed per clock, result held
// until the next commit so the downstream display never sees partial values.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : in_bin valid
//   in_ready   : idle and accepting (decoded from state, low during reset)
//   in_bin     : unsigned binary value, clamped to 10^DIGITS-1
//   bcd_out    : packed BCD, digit 0 in [3:0], held between conversions
//   overflow   : last committed result was clamped
//   done       : one-cycle pulse when bcd_out is updated
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              in_bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow,
  output logic                          done
);

  localparam int unsigned BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int unsigned MAX_VAL   = bcd_max(DIGITS);
  localparam int unsigned CNT_W     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_e             state_q,    state_d;
  logic [BIN_W-1:0]   bin_q,      bin_d;
  logic [BCD_W-1:0]   scratch_q,  scratch_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q,      bcd_d;
  logic               overflow_q, overflow_d;
  logic               done_q,     done_d;

  logic [BCD_W-1:0]   scratch_adj;
  logic               in_ovf;
  logic [BIN_W-1:0]   in_clamped;

  // Input clamp to the largest displayable value
  always_comb begin
    in_ovf     = (32'(in_bin) > MAX_VAL);
    in_clamped = in_ovf ? BIN_W'(MAX_VAL) : in_bin;
  end

  // Per-digit add-3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bin_d      = in_clamped;
          scratch_d  = '0;
          ovf_pend_d = in_ovf;
          cnt_d      = '0;
          state_d    = ST_CONV;
        end
      end

      ST_CONV: begin
        // scratch and bin shift as one register after correction
        {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_COMMIT: begin
        bcd_d      = scratch_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
module tb_bin_to_bcd;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned MAXV   = 9999;
  localparam int LAT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  in_bin;
  logic [15:0]       bcd_out;
  logic              overflow;
  logic              done;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [15:0]      bcd;
    logic             ovf;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bin   (in_bin),
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .done     (done)
  );

  // done pulses counted on the edge that ends each cycle
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Decimal digits by plain arithmetic, after clamping
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    x = (v > MAXV) ? MAXV : v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns #1 after the accepting edge
  task automatic accept(input logic [BIN_W-1:0] v);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bin   = BIN_W'($urandom);
  endtask

  // Waits for done (bounded); returns at the negedge where done is seen
  task automatic wait_done(input string name, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input bit noise);
    logic [15:0] held;
    logic        held_ovf;
    bit          ready_ok, hold_ok, got;
    int          lat;
    held     = bcd_out;
    held_ovf = overflow;
    ready_ok = 1'b1;
    hold_ok  = 1'b1;
    got      = 1'b0;
    lat      = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (noise) begin
        if (k < 15) begin
          in_valid = 1'b1;
          in_bin   = BIN_W'(42);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (done === 1'b1) begin
        got = 1'b1;
        lat = k;
      end else begin
        if (in_ready !== 1'b0) ready_ok = 1'b0;
        if (bcd_out !== held || overflow !== held_ovf) hold_ok = 1'b0;
      end
    end
    in_valid = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    check({name, "_busy"}, 32'(ready_ok), 32'd1);
    check({name, "_hold"}, 32'(hold_ok), 32'd1);
    check({name, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    check({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({name, "_ready_at_done"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int d0;
    int unsigned v;
    int n_rnd;

    tbl[0]  = '{14'd0,     16'h0000, 1'b0};
    tbl[1]  = '{14'd1234,  16'h1234, 1'b0};
    tbl[2]  = '{14'd9999,  16'h9999, 1'b0};
    tbl[3]  = '{14'd10000, 16'h9999, 1'b1};
    tbl[4]  = '{14'd16383, 16'h9999, 1'b1};
    tbl[5]  = '{14'd1,     16'h0001, 1'b0};
    tbl[6]  = '{14'd5,     16'h0005, 1'b0};
    tbl[7]  = '{14'd10,    16'h0010, 1'b0};
    tbl[8]  = '{14'd99,    16'h0099, 1'b0};
    tbl[9]  = '{14'd1000,  16'h1000, 1'b0};
    tbl[10] = '{14'd8765,  16'h8765, 1'b0};
    tbl[11] = '{14'd9998,  16'h9998, 1'b0};

    // Reset with in_valid asserted: reset wins
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bin   = 14'd123;
    repeat (3) @(negedge clk);
    check("rst_ready_low", 32'(in_ready), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_no_accept", 32'(in_ready), 32'd1);

    // Table vectors, back-to-back
    foreach (tbl[i]) begin
      accept(tbl[i].bin);
      wait_done($sformatf("tbl%0d", i), tbl[i].bcd, tbl[i].ovf, 1'b0);
    end

    // in_valid during CONV is ignored
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    accept(14'd7);
    wait_done("noise7", 16'h0007, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("noise_one_done", 32'(done_cnt - d0), 32'd1);
    check("noise_bcd_held", 32'(bcd_out), 32'h0007);
    check("noise_idle", 32'(in_ready), 32'd1);

    // Reset mid-conversion aborts without done
    accept(14'd5678);
    wait_done("c5678", 16'h5678, 1'b0, 1'b0);
    accept(14'd4321);
    repeat (7) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_bcd_held", 32'(bcd_out), 32'd0);
    accept(14'd4321);
    wait_done("c4321", 16'h4321, 1'b0, 1'b0);

    // Strided sweep plus random values against the model
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    n_rnd = 0;
    for (int unsigned s = 0; s <= MAXV; s += 97) begin
      accept(BIN_W'(s));
      wait_done("sweep", ref_bcd(s), 1'b0, 1'b0);
      n_rnd++;
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(9990, 10010);
      else v = $urandom_range(0, 16383);
      accept(BIN_W'(v));
      wait_done("rnd", ref_bcd(v), (v > MAXV), 1'b0);
      n_rnd++;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("rnd_done_count", 32'(done_cnt - d0), 32'(n_rnd));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential double-dabble converter that turns an unsigned binary count into packed BCD for the four-digit seven-segment display stage. Sits directly upstream of the display controller: its held `bcd_out` drives that stage's 16-bit digit input, which expects digit 3 (leftmost) in bits [15:12] down to digit 0 in [3:0]. It takes one value per handshake, iterates one bit per clock, and holds the last result stable so the display never shows partial values.

## Interface

- `BIN_W`, default 14: binary input width; 14 covers 0–9999.
- `DIGITS`, default 4: BCD digits produced; `MAX` = 10^DIGITS − 1 (9999).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_bin` is valid.
- `in_ready`  out  1  block is idle and accepts input.
- `in_bin`  in  BIN_W  unsigned binary value.
- `bcd_out`  out  4*DIGITS  packed BCD, digit 0 in [3:0]; held between conversions.
- `overflow`  out  1  last committed result was clamped.
- `done`  out  1  one-cycle pulse when `bcd_out` is updated.

## Operation

- States: IDLE, CONV, COMMIT.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `min(in_bin, MAX)` into the binary shift register, clear the BCD scratch register, latch `ovf_pend` = (`in_bin` > MAX), clear iteration counter, go to CONV.
- CONV: one iteration per cycle, BIN_W iterations. Each iteration: every scratch nibble ≥ 5 gets +3; then {scratch, bin} shifts left one bit as one register. After iteration BIN_W−1, go to COMMIT.
- COMMIT: `bcd_out` ← scratch, `overflow` ← `ovf_pend`, `done` ← 1, go to IDLE.
- `in_valid` outside IDLE is ignored; `in_bin` may change freely.
- Counter width ceil(log2(BIN_W)); no wrap in CONV; it is cleared on accept.
- Scratch is 4*DIGITS bits; no nibble ever exceeds 9 after COMMIT because input is clamped.
- Reset at any cycle, including mid-CONV: state IDLE, `bcd_out`=0, `overflow`=0, `done`=0, scratch/bin/counter=0; no `done` for the aborted conversion.
- `rst` and `in_valid` together: reset wins, input not accepted.

## Timing

- `in_ready` is decoded from the registered state (IDLE) and forced 0 while `rst`=1.
- Accept edge E0; iterations on E1..E(BIN_W); commit on E(BIN_W+1) (E15 at default).
- `done`=1 and new `bcd_out`/`overflow` visible in the cycle after E15; `in_ready`=1 in that same cycle, so back-to-back accept can occur at E16.
- Throughput: one conversion per BIN_W+2 cycles (16).
- `bcd_out` and `overflow` change only at COMMIT or reset.
- Reset values: `bcd_out`=0, `overflow`=0, `done`=0, `in_ready`=1 from the first cycle after reset deasserts.

## Structure

- Shared package: state enum (IDLE/CONV/COMMIT), `BCD_DIGIT_W`=4, function computing `MAX` from DIGITS.
- One sub-module: `bcd_digit_adj` — combinational 4-bit nibble correction (≥5 → +3), instantiated DIGITS times in a generate loop.
- Top holds FSM, counter, shift registers and output registers.

## Test plan

- Reset then `in_bin`=0 → after 16 cycles `done` pulse, `bcd_out`=16'h0000, `overflow`=0.
- `in_bin`=1234 → `bcd_out`=16'h1234 in cycle after E15; `in_ready` low during E1..E15.
- `in_bin`=9999, then back-to-back `in_bin`=10000 and 16383 → 16'h9999 each, `overflow` 0 then 1 then 1.
- `in_valid`=1 with 42 during CONV of 7 → only 16'h0007 commits; 42 never appears; exactly one `done`.
- Convert 5678 (commit), start 4321, assert `rst` at E8 → `bcd_out`=0, no `done`, `in_ready`=1 after reset; next 4321 gives 16'h4321.
- Sweep 0..9999 against a reference model → every `bcd_out` matches, `done` exactly once per accept.
